// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction-fetch stage with a prefetch queue between the instruction SRAM
//   and decode. Sequential PCs are streamed into a 1-cycle-latency IMEM. Each
//   returned word is stored with its PC in a circular FIFO. Decode drains the
//   FIFO over a valid/ready handshake. A redirect from execute flushes the
//   queue and drops the in-flight read.
//
// Ports
//   clk, rst         clock; asynchronous active-low reset
//   start            fetch enable (low = issue no new IMEM reads)
//   imem_en/addr     IMEM read request and word address
//   imem_data        IMEM read data, valid the cycle after imem_en
//   redirect_valid   flush and restart fetch at redirect_pc (low 2 bits ignored)
//   id_valid/ready   head-of-queue handshake toward decode
//   id_pc/id_instr   head entry (0 when the queue is empty)
//   fq_count         queue occupancy
//   perf_fetched     words pushed        (only with FETCH_PERF_CNT_EN)
//   perf_flushes     redirect cycles     (only with FETCH_PERF_CNT_EN)
//
// Optional feature macro: FETCH_PERF_CNT_EN
module fetch_queue_unit #(
  parameter int              XLEN            = 32,
  parameter int              INST_ADDR_WIDTH = 10,
  parameter int              FQ_DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        imem_en,
  output logic [INST_ADDR_WIDTH-1:0]  imem_addr,
  input  logic [XLEN-1:0]             imem_data,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic                        id_valid,
  input  logic                        id_ready,
  output logic [XLEN-1:0]             id_pc,
  output logic [XLEN-1:0]             id_instr,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]                 perf_fetched,
  output logic [31:0]                 perf_flushes,
`endif
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  fq_entry_t       fq [FQ_DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pc, req_pc;
  logic            inflight;

  logic            pop, push, issue;
  logic [CW:0]     credit;

  // Occupancy after this cycle's pop, counting the word already on its way
  // from IMEM. Issuing only while this is below depth guarantees the
  // response always has a free slot. count + inflight >= pop always holds,
  // so this value cannot underflow.
  assign pop    = id_valid & id_ready & ~redirect_valid;
  assign credit = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue  = start & ~redirect_valid & (credit < (CW+1)'(FQ_DEPTH));
  assign push   = inflight & ~redirect_valid;

  // The rst gate keeps the request low while reset is held, even with start=1.
  assign imem_en   = issue & rst;
  assign imem_addr = pc[INST_ADDR_WIDTH+1:2];
  assign fq_count  = count;
  assign id_valid  = (count != '0);
  assign id_pc     = id_valid ? fq[head].pc    : '0;
  assign id_instr  = id_valid ? fq[head].instr : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= {RESET_PC[XLEN-1:2], 2'b00};
      req_pc   <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      // The response due next cycle belongs to the old path. Clearing
      // inflight makes that response be ignored.
      pc       <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        pc     <= pc + XLEN'(4);
        req_pc <= pc;
      end
      inflight <= issue;
      if (pop)  head <= head + 1'b1;
      if (push) tail <= tail + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset. Entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) fq[tail] <= '{pc: req_pc, instr: imem_data};
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (push)           perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Testbench for fetch_queue_unit using default parameters (depth 4, RESET_PC 0).
// The IMEM model returns memf(addr) one cycle after a request. A queue-based
// reference model predicts every output at each negedge. Directed phases pin
// the model with hand-computed literals. A randomized phase follows them.
module tb_fetch_queue_unit;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc, id_instr;
  logic [2:0]  fq_count;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_flushes;
`endif

  int checks = 0;
  int fails  = 0;

  fetch_queue_unit dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched), .perf_flushes(perf_flushes),
`endif
    .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [9:0] a);
    return {a, a, a, 2'b01} ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) if (imem_en) imem_data <= memf(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the queue contents, the fetch PC, and the pending read.
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  ent_t        mq[$];
  logic [31:0] mpc = '0;
  logic [31:0] mreq = '0;
  bit          mpend = 0;
  logic [31:0] mfetched = '0, mflushes = '0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_imem_en", imem_en, 0);
      chk("rst_id_valid", id_valid, 0);
      chk("rst_id_pc", id_pc, 0);
      chk("rst_id_instr", id_instr, 0);
      chk("rst_fq_count", fq_count, 0);
      mq.delete(); mpend = 0; mpc = '0;
      mfetched = '0; mflushes = '0;
    end else begin
      int  n;
      bit  v, pop, iss;
      n = mq.size();
      v = (n != 0);
      chk("fq_count", fq_count, n);
      chk("id_valid", id_valid, v);
      chk("id_pc", id_pc, v ? mq[0].pc : 32'h0);
      chk("id_instr", id_instr, v ? mq[0].instr : 32'h0);
      pop = v && id_ready && !redirect_valid;
      iss = start && !redirect_valid && (n + int'(mpend) - int'(pop) < D);
      chk("imem_en", imem_en, iss);
      chk("imem_addr", imem_addr, mpc[11:2]);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, mfetched);
      chk("perf_flushes", perf_flushes, mflushes);
`endif
      if (redirect_valid) begin
        mq.delete(); mpend = 0; mpc = redirect_pc & ~32'h3;
        mflushes++;
      end else begin
        if (pop) void'(mq.pop_front());
        if (mpend) begin
          mq.push_back('{pc: mreq, instr: memf(mreq[11:2])});
          mfetched++;
        end
        if (iss) begin mreq = mpc; mpc = mpc + 32'd4; end
        mpend = iss;
      end
    end
  end

  task automatic cyc(input logic s, input logic r, input logic rv, input logic [31:0] rp);
    @(posedge clk); #1;
    start = s; id_ready = r; redirect_valid = rv; redirect_pc = rp;
  endtask

  task automatic cycn(input logic s, input logic r, input logic rv, input logic [31:0] rp);
    cyc(s, r, rv, rp);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    // Streaming from reset at full rate.
    @(posedge clk); #1; rst = 1'b1; start = 1'b1; id_ready = 1'b1;
    @(negedge clk);
    chk("c0_en", imem_en, 1); chk("c0_addr", imem_addr, 0); chk("c0_valid", id_valid, 0);
    cycn(1, 1, 0, 0); chk("c1_addr", imem_addr, 1); chk("c1_valid", id_valid, 0);
    cycn(1, 1, 0, 0); chk("c2_pc", id_pc, 32'h0); chk("c2_instr", id_instr, 32'hC0DE0001);
    cycn(1, 1, 0, 0); chk("c3_pc", id_pc, 32'h4); chk("c3_instr", id_instr, 32'hC09E1005);
    cycn(1, 1, 0, 0); chk("c4_pc", id_pc, 32'h8); chk("c4_instr", id_instr, 32'hC05E2009);
    // Decode stalls; the queue saturates with no drop.
    repeat (9) cyc(1, 0, 0, 0);
    cycn(1, 0, 0, 0);
    chk("stall_count", fq_count, 4); chk("stall_en", imem_en, 0); chk("stall_pc", id_pc, 32'hC);
    // Pop one entry: 3 queued and 1 in flight. Then redirect while ready=1.
    cycn(1, 1, 0, 0);
    cycn(1, 1, 1, 32'h40); chk("redir_count", fq_count, 3); chk("redir_valid", id_valid, 1);
    cycn(1, 1, 0, 0); chk("post_redir_count", fq_count, 0);
    chk("post_redir_en", imem_en, 1); chk("post_redir_addr", imem_addr, 10'h10);
    cycn(1, 1, 0, 0); chk("post_redir_valid", id_valid, 0);
    cycn(1, 1, 0, 0); chk("redir_pc", id_pc, 32'h40); chk("redir_instr", id_instr, 32'hC4DF0041);
    // The fetch PC wraps at the top of the address space. The low bits of redirect_pc are dropped.
    cycn(1, 1, 1, 32'hFFFF_FFFE);
    cycn(1, 1, 0, 0); chk("wrap_addr0", imem_addr, 10'h3FF);
    cycn(1, 1, 0, 0); chk("wrap_addr1", imem_addr, 10'h000);
    cycn(1, 1, 0, 0); chk("wrap_pc0", id_pc, 32'hFFFF_FFFC);
    cycn(1, 1, 0, 0); chk("wrap_pc1", id_pc, 32'h0);
    // Build 2 queued and 1 in flight, then assert reset asynchronously.
    cyc(1, 0, 0, 0);
    cycn(1, 0, 0, 0); chk("pre_rst_count", fq_count, 2);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk); chk("midrst_valid", id_valid, 0); chk("midrst_en", imem_en, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1; rst = 1'b1; start = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0;
    @(negedge clk); chk("rst2_en", imem_en, 1); chk("rst2_addr", imem_addr, 0);
    cyc(1, 1, 0, 0);
    cycn(1, 1, 0, 0); chk("rst2_pc", id_pc, 32'h0); chk("rst2_instr", id_instr, 32'hC0DE0001);

    // Randomized phase. The reference model checks outputs every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 24) == 0, rp);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
      end
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
